// File: rtl/oh_pads_ctrl.sv
// Per-side padring control: shadow pad configuration, staged pad enable sequencer, din return path.
// Define OH_PADS_CTRL_SYNC_EN to pass pad_din through a 2-flop synchronizer; otherwise core_din = pad_din.
module oh_pads_ctrl #(
  parameter int unsigned NGPIO = 8,
  parameter int unsigned GROUP = 4,
  parameter int unsigned DELAY = 16,
  parameter int unsigned AW    = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 reg_write,
  input  logic                 reg_read,
  output logic                 reg_ready,
  input  logic [AW-1:0]        reg_addr,
  input  logic [9:0]           reg_wdata,
  output logic [9:0]           reg_rdata,
  output logic                 reg_rvalid,
  output logic                 reg_err,
  input  logic                 go,
  input  logic                 off,
  output logic                 done,
  output logic [NGPIO*8-1:0]   cfg,
  output logic [NGPIO-1:0]     ie,
  output logic [NGPIO-1:0]     oen,
  input  logic [NGPIO-1:0]     pad_din,
  output logic [NGPIO-1:0]     core_din
);

  localparam int unsigned NGRP = (NGPIO + GROUP - 1) / GROUP;
  localparam int unsigned KW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int unsigned CW   = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [KW-1:0] KLAST  = KW'(NGRP - 1);
  localparam logic [CW-1:0] CLOAD  = CW'(DELAY - 1);
  localparam logic [AW-1:0] NGPIO_A = AW'(NGPIO);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NGPIO-1:0]  mask_q, mask_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic [NGPIO-1:0][7:0] sh_cfg_q;
  logic [NGPIO-1:0]      sh_ie_q;
  logic [NGPIO-1:0]      sh_oen_q;

  logic [9:0]          rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [NGPIO*8-1:0]  cfg_q, cfg_d;
  logic [NGPIO-1:0]    ie_q, ie_d;
  logic [NGPIO-1:0]    oen_q, oen_d;

  logic                wr_acc_c, rd_acc_c, addr_ok_c;
  logic [9:0]          rd_sel_c;
  logic [NGPIO-1:0]    grp_mask_c;

  // Pads belonging to the group currently being released.
  always_comb begin
    grp_mask_c = '0;
    for (int i = 0; i < int'(NGPIO); i++) begin
      if (i >= int'(k_q) * int'(GROUP) && i < (int'(k_q) + 1) * int'(GROUP))
        grp_mask_c[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    if (off) begin
      state_d = S_IDLE;
      k_d     = '0;
      cnt_d   = '0;
      mask_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_d = S_STEP;
            k_d     = '0;
          end
        end
        S_STEP: begin
          mask_d = mask_q | grp_mask_c;
          if (k_q == KLAST) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + KW'(1);
            cnt_d   = CLOAD;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_d = S_STEP;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_DONE: begin
          if (!go) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    ready_d = (state_d != S_STEP);
    done_d  = (state_d == S_DONE);
  end

  // Register port decode; out-of-range accesses read as zero and flag an error.
  always_comb begin
    wr_acc_c  = reg_write & ready_q;
    rd_acc_c  = reg_read & ~reg_write & ready_q;
    addr_ok_c = (reg_addr < NGPIO_A);
    rd_sel_c  = '0;
    for (int i = 0; i < int'(NGPIO); i++) begin
      if (reg_addr == AW'(i)) rd_sel_c = {sh_oen_q[i], sh_ie_q[i], sh_cfg_q[i]};
    end
    rdata_d  = rd_acc_c ? (addr_ok_c ? rd_sel_c : 10'h000) : rdata_q;
    rvalid_d = rd_acc_c;
    err_d    = (wr_acc_c | rd_acc_c) & ~addr_ok_c;
  end

  // Masked pads are held in the safe state: cfg=0, ie=0, oen=1.
  always_comb begin
    cfg_d = '0;
    ie_d  = '0;
    oen_d = '1;
    for (int i = 0; i < int'(NGPIO); i++) begin
      cfg_d[i*8 +: 8] = mask_q[i] ? sh_cfg_q[i] : 8'h00;
      ie_d[i]         = mask_q[i] & sh_ie_q[i];
      oen_d[i]        = ~mask_q[i] | sh_oen_q[i];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      cfg_q    <= '0;
      ie_q     <= '0;
      oen_q    <= '1;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      cfg_q    <= cfg_d;
      ie_q     <= ie_d;
      oen_q    <= oen_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sh_cfg_q <= '0;
      sh_ie_q  <= '0;
      sh_oen_q <= '1;
    end else begin
      for (int i = 0; i < int'(NGPIO); i++) begin
        if (wr_acc_c && reg_addr == AW'(i)) begin
          sh_cfg_q[i] <= reg_wdata[7:0];
          sh_ie_q[i]  <= reg_wdata[8];
          sh_oen_q[i] <= reg_wdata[9];
        end
      end
    end
  end

`ifdef OH_PADS_CTRL_SYNC_EN
  logic [NGPIO-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_din;
      sync2_q <= sync1_q;
    end
  end

  assign core_din = sync2_q;
`else
  assign core_din = pad_din;
`endif

  assign reg_ready  = ready_q;
  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign reg_err    = err_q;
  assign done       = done_q;
  assign cfg        = cfg_q;
  assign ie         = ie_q;
  assign oen        = oen_q;

endmodule

// File: tb/tb_oh_pads_ctrl.sv
// Bench for oh_pads_ctrl: time-based reference model with per-cycle compare, plus directed literal checks.
module tb_oh_pads_ctrl;
  localparam int NG   = 8;
  localparam int GR   = 3;
  localparam int DL   = 4;
  localparam int AW   = 8;
  localparam int NGRP = (NG + GR - 1) / GR;

  logic            clk = 1'b0;
  logic            nreset = 1'b1;
  logic            reg_write, reg_read, reg_ready;
  logic [AW-1:0]   reg_addr;
  logic [9:0]      reg_wdata, reg_rdata;
  logic            reg_rvalid, reg_err;
  logic            go, off, done;
  logic [NG*8-1:0] cfg;
  logic [NG-1:0]   ie, oen, pad_din, core_din;

  always #5 clk = ~clk;

  oh_pads_ctrl #(.NGPIO(NG), .GROUP(GR), .DELAY(DL), .AW(AW)) dut (
    .clk(clk), .nreset(nreset),
    .reg_write(reg_write), .reg_read(reg_read), .reg_ready(reg_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .reg_err(reg_err),
    .go(go), .off(off), .done(done),
    .cfg(cfg), .ie(ie), .oen(oen),
    .pad_din(pad_din), .core_din(core_din)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sequencer tracked as edges elapsed since go was taken.
  typedef enum {M_IDLE, M_RUN, M_DONE} mmode_e;
  mmode_e          mode;
  int              age;
  logic [NG-1:0]   msk;
  logic [7:0]      s_cfg [NG];
  logic [NG-1:0]   s_ie, s_oen;
  logic [63:0]     e_cfg;
  logic [NG-1:0]   e_ie, e_oen, e_s1, e_s2;
  logic [9:0]      e_rdata;
  logic            e_rvalid, e_err, e_ready, e_done;
  logic            m_wa, m_ra;
  int              m_a;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mode = M_IDLE; age = 0; msk = '0;
      for (int i = 0; i < NG; i++) s_cfg[i] = 8'h00;
      s_ie = '0; s_oen = '1;
      e_cfg = '0; e_ie = '0; e_oen = '1; e_rdata = '0;
      e_rvalid = 1'b0; e_err = 1'b0; e_ready = 1'b1; e_done = 1'b0;
      e_s1 = '0; e_s2 = '0;
    end else begin
      m_wa = reg_write && e_ready;
      m_ra = reg_read && !reg_write && e_ready;
      m_a  = int'(reg_addr);
      for (int i = 0; i < NG; i++) begin
        e_cfg[i*8 +: 8] = msk[i] ? s_cfg[i] : 8'h00;
        e_ie[i]  = msk[i] ? s_ie[i] : 1'b0;
        e_oen[i] = msk[i] ? s_oen[i] : 1'b1;
      end
      e_rvalid = m_ra;
      e_err    = (m_wa || m_ra) && (m_a >= NG);
      if (m_ra) e_rdata = (m_a < NG) ? {s_oen[m_a], s_ie[m_a], s_cfg[m_a]} : 10'h000;
      if (m_wa && m_a < NG) begin
        s_cfg[m_a] = reg_wdata[7:0];
        s_ie[m_a]  = reg_wdata[8];
        s_oen[m_a] = reg_wdata[9];
      end
      if (off) begin
        mode = M_IDLE; msk = '0;
      end else if (mode == M_IDLE) begin
        if (go) begin mode = M_RUN; age = 0; end
      end else if (mode == M_RUN) begin
        age++;
        for (int k = 0; k < NGRP; k++)
          if (age == 1 + k * (DL + 1))
            for (int i = k * GR; i < (k + 1) * GR && i < NG; i++) msk[i] = 1'b1;
        if (age == 1 + (NGRP - 1) * (DL + 1)) mode = M_DONE;
      end else if (!go) begin
        mode = M_IDLE;
      end
      e_ready = !(mode == M_RUN && (age % (DL + 1)) == 0);
      e_done  = (mode == M_DONE);
      e_s2 = e_s1;
      e_s1 = pad_din;
    end
  end

  always @(posedge clk) begin
    #1;
    if (nreset) begin
      check("m_cfg", cfg, e_cfg);
      check("m_ie", ie, e_ie);
      check("m_oen", oen, e_oen);
      check("m_ready", reg_ready, e_ready);
      check("m_done", done, e_done);
      check("m_rvalid", reg_rvalid, e_rvalid);
      check("m_err", reg_err, e_err);
      check("m_rdata", reg_rdata, e_rdata);
`ifdef OH_PADS_CTRL_SYNC_EN
      check("m_core_din", core_din, e_s2);
`else
      check("m_core_din", core_din, pad_din);
`endif
    end
  end

  task automatic wr(input int a, input logic [9:0] d);
    reg_write = 1'b1; reg_addr = AW'(a); reg_wdata = d;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic rd(input int a);
    reg_read = 1'b1; reg_addr = AW'(a);
    @(negedge clk);
    reg_read = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  initial begin
    reg_write = 1'b0; reg_read = 1'b0; reg_addr = '0; reg_wdata = '0;
    go = 1'b0; off = 1'b0; pad_din = '0;
    #2 nreset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cfg", cfg, 64'h0);
    check("rst_ie", ie, 8'h00);
    check("rst_oen", oen, 8'hFF);
    check("rst_done", done, 1'b0);
    check("rst_ready", reg_ready, 1'b1);
    check("rst_rdata", reg_rdata, 10'h000);
    check("rst_core_din", core_din, 8'h00);
    nreset = 1'b1;
    @(negedge clk);
    check("idle_oen", oen, 8'hFF);

    // Program every pad, then run the full release sequence.
    for (int i = 0; i < NG; i++) wr(i, {1'b0, 1'b1, 8'(8'h10 + i)});
    pulse_go();                       // now just after edge t
    @(negedge clk);                   // t+1
    check("seq_oen_t1", oen, 8'hFF);
    @(negedge clk);                   // t+2
    check("seq_oen_t2", oen, 8'hF8);
    check("seq_ie_t2", ie, 8'h07);
    check("seq_cfg_t2", cfg, 64'h0000_0000_0012_1110);
    repeat (4) @(negedge clk);        // t+6
    check("seq_oen_t6", oen, 8'hF8);
    check("seq_done_t6", done, 1'b0);
    @(negedge clk);                   // t+7
    check("seq_oen_t7", oen, 8'hC0);
    repeat (4) @(negedge clk);        // t+11
    check("seq_done_t11", done, 1'b1);
    check("seq_oen_t11", oen, 8'hC0);
    @(negedge clk);                   // t+12
    check("seq_oen_t12", oen, 8'h00);
    check("seq_cfg_t12", cfg, 64'h1716_1514_1312_1110);
    check("seq_done_t12", done, 1'b0);

    // Out-of-range accesses.
    wr(9, 10'h3FF);
    check("oor_wr_err", reg_err, 1'b1);
    check("oor_wr_rvalid", reg_rvalid, 1'b0);
    @(negedge clk);
    check("oor_err_pulse", reg_err, 1'b0);
    rd(9);
    check("oor_rd_err", reg_err, 1'b1);
    check("oor_rd_rvalid", reg_rvalid, 1'b1);
    check("oor_rd_rdata", reg_rdata, 10'h000);
    rd(2);
    check("rd2_rdata", reg_rdata, 10'h112);
    check("rd2_err", reg_err, 1'b0);
    check("oor_no_change", cfg, 64'h1716_1514_1312_1110);

    // off during WAIT clears the mask; go restarts from group 0.
    pulse_go();                       // t
    repeat (2) @(negedge clk);        // t+2, in WAIT
    off = 1'b1;
    @(negedge clk);                   // t+3
    off = 1'b0;
    check("off_ready", reg_ready, 1'b1);
    check("off_done", done, 1'b0);
    @(negedge clk);                   // t+4
    check("off_oen", oen, 8'hFF);
    check("off_ie", ie, 8'h00);
    check("off_cfg", cfg, 64'h0);
    pulse_go();
    @(negedge clk);
    check("restart_oen_t1", oen, 8'hFF);
    @(negedge clk);
    check("restart_oen_t2", oen, 8'hF8);

    // Reset in the middle of WAIT.
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("mrst_oen", oen, 8'hFF);
    check("mrst_ie", ie, 8'h00);
    check("mrst_cfg", cfg, 64'h0);
    check("mrst_done", done, 1'b0);
    check("mrst_ready", reg_ready, 1'b1);
    check("mrst_rvalid", reg_rvalid, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    rd(3);
    check("mrst_shadow", reg_rdata, 10'h200);

    // din return path.
    pad_din = 8'hA5;
`ifdef OH_PADS_CTRL_SYNC_EN
    #1;
    check("din_t0", core_din, 8'h00);
    @(posedge clk); #1;
    check("din_t1", core_din, 8'h00);
    @(posedge clk); #1;
    check("din_t2", core_din, 8'hA5);
`else
    #1;
    check("din_t0", core_din, 8'hA5);
`endif
    @(negedge clk);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reg_write = ($urandom % 4) == 0;
      reg_read  = ($urandom % 3) == 0;
      reg_addr  = AW'($urandom_range(0, 11));
      reg_wdata = 10'($urandom);
      if (($urandom % 12) == 0) go = ~go;
      off       = ($urandom % 60) == 0;
      pad_din   = 8'($urandom);
      @(negedge clk);
    end
    reg_write = 1'b0; reg_read = 1'b0; go = 1'b0; off = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
